// File: rtl/dds_ctrl_pkg.sv
// Shared types and default widths for the DDS sweep controller and its helpers.
// DEF_DDS_LAT must track the pipeline latency of ddsx2.
package dds_ctrl_pkg;
    localparam int DEF_PHASE_W = 32;
    localparam int DEF_STEPS_W = 16;
    localparam int DEF_DWELL_W = 24;
    localparam int DEF_DDS_LAT = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DWELL = 2'd2,
        DONE  = 2'd3
    } state_t;
endpackage

// File: rtl/dds_settle_timer.sv
// Counts DDS pipeline latency after each phase-increment write; o_settled
// marks cycles where the DDS output reflects the most recent write.
module dds_settle_timer #(
    parameter int DDS_LAT = 6
) (
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_settled
);
    localparam int CNT_W = $clog2(DDS_LAT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic             armed_q;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_q   <= '0;
            armed_q <= 1'b0;
        end else if (i_clear) begin
            cnt_q   <= CNT_W'(DDS_LAT - 1);
            armed_q <= 1'b1;
        end else if (!i_enable) begin
            cnt_q   <= '0;
            armed_q <= 1'b0;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // The issue cycle itself is never settled, even if the previous count expired.
    assign o_settled = armed_q && i_enable && !i_clear && (cnt_q == '0);
endmodule

// File: rtl/dds_sweep_ctrl.sv
// Frequency sweep / hop scheduler: issues one phase-increment write per
// frequency to ddsx2, dwells D' cycles on each, optionally repeating.
module dds_sweep_ctrl
    import dds_ctrl_pkg::*;
#(
    parameter int PHASE_W = DEF_PHASE_W,
    parameter int STEPS_W = DEF_STEPS_W,
    parameter int DWELL_W = DEF_DWELL_W,
    parameter int DDS_LAT = DEF_DDS_LAT
) (
    input  logic               i_clock,
    input  logic               i_reset_n,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic [PHASE_W-1:0] i_start_inc,
    input  logic [PHASE_W-1:0] i_step_inc,
    input  logic [STEPS_W-1:0] i_num_steps,
    input  logic [DWELL_W-1:0] i_dwell,
    input  logic               i_repeat,
    output logic [PHASE_W-1:0] o_phase_inc,
    output logic               o_phase_inc_valid,
    output logic               o_dds_ready,
    output logic               o_settled,
    output logic               o_busy,
    output logic               o_done,
    output logic [STEPS_W-1:0] o_step_idx,
    output state_t             o_state
);
    state_t             state_q, state_d;
    logic [PHASE_W-1:0] start_q, start_d;
    logic [PHASE_W-1:0] step_q, step_d;
    logic [STEPS_W-1:0] last_q, last_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               rep_q, rep_d;
    logic [PHASE_W-1:0] inc_q, inc_d;
    logic [STEPS_W-1:0] idx_q, idx_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               end_of_dwell;

    always_comb begin
        end_of_dwell = (state_q == ISSUE) ? (dwell_q == DWELL_W'(1)) : (cnt_q == '0);
        state_d = state_q;
        start_d = start_q;
        step_d  = step_q;
        last_d  = last_q;
        dwell_d = dwell_q;
        rep_d   = rep_q;
        inc_d   = inc_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (i_start && !i_abort) begin
                    start_d = i_start_inc;
                    step_d  = i_step_inc;
                    last_d  = (i_num_steps == '0) ? '0 : i_num_steps - STEPS_W'(1);
                    dwell_d = (i_dwell == '0) ? DWELL_W'(1) : i_dwell;
                    rep_d   = i_repeat;
                    inc_d   = i_start_inc;
                    idx_d   = '0;
                    cnt_d   = '0;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE, DWELL: begin
                if (!end_of_dwell) begin
                    // The issue cycle counts as dwell cycle 1, hence D'-2 remaining.
                    cnt_d   = (state_q == ISSUE) ? dwell_q - DWELL_W'(2) : cnt_q - DWELL_W'(1);
                    state_d = DWELL;
                end else if (idx_q != last_q) begin
                    idx_d   = idx_q + STEPS_W'(1);
                    inc_d   = inc_q + step_q;
                    valid_d = 1'b1;
                    state_d = ISSUE;
                end else if (rep_q) begin
                    idx_d   = '0;
                    inc_d   = start_q;
                    valid_d = 1'b1;
                    state_d = ISSUE;
                end else begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (i_abort && state_q != IDLE) begin
            state_d = IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            start_q <= '0;
            step_q  <= '0;
            last_q  <= '0;
            dwell_q <= '0;
            rep_q   <= 1'b0;
            inc_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            step_q  <= step_d;
            last_q  <= last_d;
            dwell_q <= dwell_d;
            rep_q   <= rep_d;
            inc_q   <= inc_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    dds_settle_timer #(.DDS_LAT(DDS_LAT)) u_settle (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_clear   (valid_q),
        .i_enable  (busy_q),
        .o_settled (o_settled)
    );

    assign o_phase_inc       = inc_q;
    assign o_phase_inc_valid = valid_q;
    assign o_dds_ready       = busy_q;
    assign o_busy            = busy_q;
    assign o_done            = done_q;
    assign o_step_idx        = idx_q;
    assign o_state           = state_q;
endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Self-checking bench for dds_sweep_ctrl: expected valid pulses and done
// pulses are queued at stimulus time and matched as the DUT produces them.
module tb_dds_sweep_ctrl;
    import dds_ctrl_pkg::*;

    localparam int LAT = 6;
    localparam int W   = 80;

    logic        clk;
    logic        rst_n;
    logic        i_start, i_abort, i_repeat;
    logic [31:0] i_start_inc, i_step_inc;
    logic [15:0] i_num_steps;
    logic [23:0] i_dwell;
    logic [31:0] o_phase_inc;
    logic        o_phase_inc_valid, o_dds_ready, o_settled, o_busy, o_done;
    logic [15:0] o_step_idx;
    state_t      o_state;

    dds_sweep_ctrl dut (
        .i_clock           (clk),
        .i_reset_n         (rst_n),
        .i_start           (i_start),
        .i_abort           (i_abort),
        .i_start_inc       (i_start_inc),
        .i_step_inc        (i_step_inc),
        .i_num_steps       (i_num_steps),
        .i_dwell           (i_dwell),
        .i_repeat          (i_repeat),
        .o_phase_inc       (o_phase_inc),
        .o_phase_inc_valid (o_phase_inc_valid),
        .o_dds_ready       (o_dds_ready),
        .o_settled         (o_settled),
        .o_busy            (o_busy),
        .o_done            (o_done),
        .o_step_idx        (o_step_idx),
        .o_state           (o_state)
    );

    // clock / reset
    int unsigned cyc = 0;
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard state: entry = {cycle, step_idx, phase_inc}
    logic [W-1:0] exp_q[$];
    int unsigned  done_q[$];
    int unsigned  busy_from = 1, busy_to = 0;
    int unsigned  last_pulse = 0;
    bit           has_pulse = 0;
    bit           mon_en = 0;
    int unsigned  t0;
    int           n_checks = 0, n_fail = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    // monitor
    logic [W-1:0] e;
    bit           exp_b, pulse_now;
    always @(negedge clk) begin
        if (mon_en) begin
            pulse_now = (exp_q.size() > 0) && (exp_q[0][79:48] == cyc);
            exp_b     = (cyc >= busy_from) && (cyc <= busy_to);
            check_eq("busy", 64'(o_busy), 64'(exp_b));
            check_eq("dds_ready", 64'(o_dds_ready), 64'(exp_b));
            check_eq("settled", 64'(o_settled),
                     64'(exp_b && has_pulse && !pulse_now && (cyc - last_pulse >= LAT)));
            if (o_phase_inc_valid) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_valid", 64'(1), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check_eq("valid_cycle", 64'(cyc), 64'(e[79:48]));
                    check_eq("phase_inc", 64'(o_phase_inc), 64'(e[31:0]));
                    check_eq("step_idx", 64'(o_step_idx), 64'(e[47:32]));
                    last_pulse = e[79:48];
                    has_pulse  = 1'b1;
                end
            end else if (exp_q.size() > 0 && exp_q[0][79:48] < cyc) begin
                e = exp_q.pop_front();
                check_eq("missing_valid", 64'(cyc), 64'(e[79:48]));
            end
            if (o_done) begin
                if (done_q.size() == 0) check_eq("unexpected_done", 64'(1), 64'(0));
                else check_eq("done_cycle", 64'(cyc), 64'(done_q.pop_front()));
            end else if (done_q.size() > 0 && done_q[0] < cyc) begin
                check_eq("missing_done", 64'(cyc), 64'(done_q.pop_front()));
            end
        end
    end

    // driver tasks
    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_sweep(input logic [31:0] s, input logic [31:0] st, input int n,
                               input int d, input bit rep, input int rep_pulses);
        int np, dp, cnt, k;
        logic [31:0] inc;
        @(negedge clk);
        np = (n == 0) ? 1 : n;
        dp = (d == 0) ? 1 : d;
        i_start_inc = s;
        i_step_inc  = st;
        i_num_steps = 16'(n);
        i_dwell     = 24'(d);
        i_repeat    = rep;
        i_start     = 1'b1;
        t0  = cyc;
        cnt = rep ? rep_pulses : np;
        inc = s;
        k   = 0;
        for (int j = 0; j < cnt; j++) begin
            exp_q.push_back({32'(t0 + 1 + j * dp), 16'(k), inc});
            k++;
            inc = inc + st;
            if (k == np) begin
                k   = 0;
                inc = s;
            end
        end
        busy_from = t0 + 1;
        busy_to   = rep ? 32'hFFFF_FFFF : t0 + np * dp;
        if (!rep) done_q.push_back(t0 + 1 + np * dp);
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_phase_inc"}, 64'(o_phase_inc), 64'(0));
        check_eq({tag, "_valid"}, 64'(o_phase_inc_valid), 64'(0));
        check_eq({tag, "_dds_ready"}, 64'(o_dds_ready), 64'(0));
        check_eq({tag, "_settled"}, 64'(o_settled), 64'(0));
        check_eq({tag, "_busy"}, 64'(o_busy), 64'(0));
        check_eq({tag, "_done"}, 64'(o_done), 64'(0));
        check_eq({tag, "_step_idx"}, 64'(o_step_idx), 64'(0));
    endtask

    initial begin
        rst_n = 1'b0;
        i_start = 1'b0; i_abort = 1'b0; i_repeat = 1'b0;
        i_start_inc = '0; i_step_inc = '0; i_num_steps = '0; i_dwell = '0;
        wait_cyc(3);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;
        wait_cyc(2);

        // basic sweep
        start_sweep(32'h1000_0000, 32'h0100_0000, 3, 4, 1'b0, 0);
        wait_cyc(16);
        // wrap past 2^32 and negative step
        start_sweep(32'hFF00_0000, 32'h0200_0000, 2, 3, 1'b0, 0);
        wait_cyc(9);
        start_sweep(32'h0080_0000, 32'hFF00_0000, 2, 2, 1'b0, 0);
        wait_cyc(7);
        // degenerate descriptors
        start_sweep(32'h0000_1234, 32'h0000_0001, 0, 0, 1'b0, 0);
        wait_cyc(4);
        start_sweep(32'h0000_0100, 32'h0000_0100, 4, 1, 1'b0, 0);
        wait_cyc(7);
        // settle timing
        start_sweep(32'h0123_4567, 32'h0000_1000, 2, 10, 1'b0, 0);
        wait_cyc(23);
        start_sweep(32'h0765_4321, 32'h0010_0000, 3, 5, 1'b0, 0);
        wait_cyc(18);
        // random short sweeps
        for (int r = 0; r < 4; r++) begin
            int rn, rd;
            rn = $urandom_range(1, 4);
            rd = $urandom_range(1, 9);
            start_sweep($urandom, $urandom, rn, rd, 1'b0, 0);
            wait_cyc(rn * rd + 3);
        end

        // repeat then abort mid-dwell
        start_sweep(32'h2000_0000, 32'h0010_0000, 2, 3, 1'b1, 4);
        while (cyc < t0 + 11) @(negedge clk);
        i_abort = 1'b1;
        busy_to = t0 + 11;
        @(negedge clk);
        i_abort = 1'b0;
        check_eq("abort_phase_hold", 64'(o_phase_inc), 64'(32'h2010_0000));
        check_eq("abort_idx_hold", 64'(o_step_idx), 64'(1));
        wait_cyc(8);

        // start and abort together in idle
        @(negedge clk);
        i_start = 1'b1; i_abort = 1'b1; i_num_steps = 16'd2; i_dwell = 24'd2;
        @(negedge clk);
        i_start = 1'b0; i_abort = 1'b0;
        wait_cyc(6);

        // start while busy is ignored, descriptor pins may change freely
        start_sweep(32'h0000_0100, 32'h0000_0010, 2, 6, 1'b0, 0);
        wait_cyc(2);
        i_start = 1'b1; i_start_inc = 32'hDEAD_BEEF; i_step_inc = 32'h1111_1111;
        i_num_steps = 16'd9; i_dwell = 24'd2; i_repeat = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        wait_cyc(14);

        // async reset mid-dwell
        start_sweep(32'h0ABC_0000, 32'h0000_0001, 3, 8, 1'b0, 0);
        while (cyc < t0 + 3) @(negedge clk);
        mon_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        exp_q.delete();
        done_q.delete();
        busy_to   = 0;
        has_pulse = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;
        wait_cyc(12);

        // post-reset sweep still works
        start_sweep(32'h0000_0042, 32'h0000_0002, 2, 2, 1'b0, 0);
        wait_cyc(8);

        check_eq("exp_q_drained", 64'(exp_q.size()), 64'(0));
        check_eq("done_q_drained", 64'(done_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
